// File: rtl/wb_intercon_reg.sv
// Registered single-master Wishbone interconnect: decodes one master onto NS slaves,
// forwards the bus through registers, and reports unmapped/timeout errors.
module wb_intercon_reg #(
    parameter int               DW        = 32,
    parameter int               AW        = 32,
    parameter int               NS        = 6,
    parameter logic [NS*AW-1:0] ADR_MASK  = {NS{32'hFF00_0000}},
    parameter logic [NS*AW-1:0] SLAVE_ADR = {32'h2800_0000, 32'h2200_0000, 32'h2100_0000,
                                             32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter int               TIMEOUT   = 255,
    parameter int               TW        = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbm_cyc_i,
    input  logic               wbm_stb_i,
    input  logic               wbm_we_i,
    input  logic [DW/8-1:0]    wbm_sel_i,
    input  logic [AW-1:0]      wbm_adr_i,
    input  logic [DW-1:0]      wbm_dat_i,
    output logic [DW-1:0]      wbm_dat_o,
    output logic               wbm_ack_o,
    output logic               wbm_err_o,
    output logic               wbs_cyc_o,
    output logic [NS-1:0]      wbs_stb_o,
    output logic               wbs_we_o,
    output logic [DW/8-1:0]    wbs_sel_o,
    output logic [AW-1:0]      wbs_adr_o,
    output logic [DW-1:0]      wbs_dat_o,
    input  logic [NS*DW-1:0]   wbs_dat_i,
    input  logic [NS-1:0]      wbs_ack_i,
    output logic               timeout_o,
    output logic [AW-1:0]      err_adr_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [NS-1:0]     stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [DW/8-1:0]   bsel_q, bsel_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     wdat_q, wdat_d;
    logic [DW-1:0]     rdat_q, rdat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              to_q, to_d;
    logic [AW-1:0]     err_adr_q, err_adr_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              resp_ack_q, resp_ack_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_to_q, resp_to_d;

    logic [NS-1:0]     hit;
    logic [NS-1:0]     onehot;
    logic              sel_ack;
    logic [DW-1:0]     sel_dat;
    logic              expire;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_dec
            assign hit[gi] = ((wbm_adr_i & ADR_MASK[gi*AW +: AW]) == SLAVE_ADR[gi*AW +: AW]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index ends up selected.
    always_comb begin
        onehot = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    // stb_q is one-hot during ACCESS, so masking with it honours only the selected slave.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NS; i++) begin
            if (stb_q[i]) begin
                sel_dat = sel_dat | wbs_dat_i[i*DW +: DW];
            end
        end
    end

    assign sel_ack = |(wbs_ack_i & stb_q);
    assign expire  = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        bsel_d     = bsel_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        to_d       = 1'b0;
        err_adr_d  = err_adr_q;
        cnt_d      = cnt_q;
        resp_ack_d = resp_ack_q;
        resp_err_d = resp_err_q;
        resp_to_d  = resp_to_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wbm_cyc_i && wbm_stb_i) begin
                    adr_d  = wbm_adr_i;
                    we_d   = wbm_we_i;
                    bsel_d = wbm_sel_i;
                    wdat_d = wbm_dat_i;
                    if (|hit) begin
                        stb_d   = onehot;
                        cyc_d   = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        err_adr_d  = wbm_adr_i;
                        resp_ack_d = 1'b0;
                        resp_err_d = 1'b1;
                        resp_to_d  = 1'b0;
                        state_d    = RESP;
                    end
                end
            end

            ACCESS: begin
                if (!wbm_cyc_i) begin
                    stb_d   = '0;
                    cyc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    rdat_d     = sel_dat;
                    resp_ack_d = 1'b1;
                    resp_err_d = 1'b0;
                    resp_to_d  = 1'b0;
                    stb_d      = '0;
                    cyc_d      = 1'b0;
                    state_d    = RESP;
                end else if (expire) begin
                    err_adr_d  = adr_q;
                    resp_ack_d = 1'b0;
                    resp_err_d = 1'b1;
                    resp_to_d  = 1'b1;
                    stb_d      = '0;
                    cyc_d      = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end

            RESP: begin
                ack_d   = resp_ack_q;
                err_d   = resp_err_q;
                to_d    = resp_to_q;
                stb_d   = '0;
                cyc_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                stb_d   = '0;
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            stb_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            bsel_q     <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
            err_adr_q  <= '0;
            cnt_q      <= '0;
            resp_ack_q <= 1'b0;
            resp_err_q <= 1'b0;
            resp_to_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stb_q      <= stb_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            bsel_q     <= bsel_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            to_q       <= to_d;
            err_adr_q  <= err_adr_d;
            cnt_q      <= cnt_d;
            resp_ack_q <= resp_ack_d;
            resp_err_q <= resp_err_d;
            resp_to_q  <= resp_to_d;
        end
    end

    assign wbm_dat_o = rdat_q;
    assign wbm_ack_o = ack_q;
    assign wbm_err_o = err_q;
    assign wbs_cyc_o = cyc_q;
    assign wbs_stb_o = stb_q;
    assign wbs_we_o  = we_q;
    assign wbs_sel_o = bsel_q;
    assign wbs_adr_o = adr_q;
    assign wbs_dat_o = wdat_q;
    assign timeout_o = to_q;
    assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_wb_intercon_reg.sv
// Directed bench for wb_intercon_reg with a short watchdog (TIMEOUT=4) so expiry is reachable.
module tb_wb_intercon_reg;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              wbm_cyc_i, wbm_stb_i, wbm_we_i;
    logic [DW/8-1:0]   wbm_sel_i;
    logic [AW-1:0]     wbm_adr_i;
    logic [DW-1:0]     wbm_dat_i;
    logic [DW-1:0]     wbm_dat_o;
    logic              wbm_ack_o, wbm_err_o;
    logic              wbs_cyc_o;
    logic [NS-1:0]     wbs_stb_o;
    logic              wbs_we_o;
    logic [DW/8-1:0]   wbs_sel_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [NS*DW-1:0]  wbs_dat_i;
    logic [NS-1:0]     wbs_ack_i;
    logic              timeout_o;
    logic [AW-1:0]     err_adr_o;

    always #5 clk = ~clk;

    wb_intercon_reg #(.TIMEOUT(4)) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .timeout_o (timeout_o),
        .err_adr_o (err_adr_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results of the most recent xfer() call
    int              r_stb_cnt, r_resp, r_to_cnt;
    logic [NS-1:0]   r_stb_or;
    logic            r_ack, r_err, r_both, r_post;
    logic            s_we;
    logic [3:0]      s_sel;
    logic [31:0]     s_dat, s_adr;

    // Master issues one request; the addressed slave acks after wait_n wait states
    // (ack_idx<0: never). spur_idx, if >=0, acks continuously while any strobe is up.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input int ack_idx, input int wait_n,
                        input int spur_idx, input logic [31:0] rdat);
        for (int i = 0; i < NS; i++)
            wbs_dat_i[i*DW +: DW] = (i == ack_idx) ? rdat : (32'hBAD0_0000 | i);
        wbs_ack_i = '0;
        r_stb_cnt = 0; r_resp = 0; r_to_cnt = 0; r_stb_or = '0;
        r_ack = 0; r_err = 0; r_both = 0; r_post = 0;
        s_we = 0; s_sel = 0; s_dat = 0; s_adr = 0;
        wbm_adr_i = adr; wbm_we_i = we; wbm_dat_i = wdat; wbm_sel_i = sel;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (wbm_ack_o && wbm_err_o) r_both = 1;
            if (timeout_o) r_to_cnt++;
            if (wbs_stb_o != '0) begin
                r_stb_cnt++;
                r_stb_or |= wbs_stb_o;
                if (r_stb_cnt == 1) begin
                    s_we = wbs_we_o; s_sel = wbs_sel_o; s_dat = wbs_dat_o; s_adr = wbs_adr_o;
                end
            end
            wbs_ack_i = '0;
            if (ack_idx >= 0 && ack_idx < NS) begin
                if (wbs_stb_o[ack_idx] && (r_stb_cnt - 1 == wait_n)) wbs_ack_i[ack_idx] = 1'b1;
            end
            if (spur_idx >= 0 && spur_idx < NS && wbs_stb_o != '0) wbs_ack_i[spur_idx] = 1'b1;
            if (wbm_ack_o || wbm_err_o) begin
                r_resp = c; r_ack = wbm_ack_o; r_err = wbm_err_o;
                wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbs_ack_i = '0;
                tick();
                r_post = wbm_ack_o | wbm_err_o | timeout_o;
                break;
            end
        end
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbs_ack_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        wbm_cyc_i = 0; wbm_stb_i = 0; wbm_we_i = 0; wbm_sel_i = 0;
        wbm_adr_i = 0; wbm_dat_i = 0; wbs_dat_i = '0; wbs_ack_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", wbm_ack_o, 0);
        check("rst_err", wbm_err_o, 0);
        check("rst_cyc_stb", {wbs_cyc_o, wbs_stb_o}, 0);
        check("rst_bus", {wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o}, 0);
        check("rst_misc", {timeout_o, err_adr_o, wbm_dat_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // RAM read, immediate ack
        xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 0, -1, 32'hDEAD_BEEF);
        check("ram_stb", r_stb_or, 6'b000001);
        check("ram_stb_cnt", r_stb_cnt, 1);
        check("ram_resp_cyc", r_resp, 3);
        check("ram_ack_err", {r_ack, r_err, r_both, r_post}, 4'b1000);
        check("ram_dat", wbm_dat_o, 32'hDEAD_BEEF);
        check("ram_fwd", {s_we, s_adr}, {1'b0, 32'h0000_0010});

        // GPIO write, 3 wait states
        xfer(32'h2100_0004, 1'b1, 32'h0000_00A5, 4'b0001, 3, 3, -1, 32'h0);
        check("gpio_stb", r_stb_or, 6'b001000);
        check("gpio_stb_cnt", r_stb_cnt, 4);
        check("gpio_fwd", {s_we, s_sel, s_dat, s_adr}, {1'b1, 4'b0001, 32'h0000_00A5, 32'h2100_0004});
        check("gpio_resp_cyc", r_resp, 6);
        check("gpio_ack_err", {r_ack, r_err, r_both, r_post}, 4'b1000);
        check("gpio_to", r_to_cnt, 0);

        // Unmapped address
        xfer(32'h3000_0000, 1'b0, 32'h0, 4'hF, -1, 0, -1, 32'h0);
        check("unm_stb_cnt", r_stb_cnt, 0);
        check("unm_resp_cyc", r_resp, 2);
        check("unm_ack_err", {r_ack, r_err, r_both, r_post}, 4'b0100);
        check("unm_err_adr", err_adr_o, 32'h3000_0000);
        check("unm_to", r_to_cnt, 0);

        // UART, no ack: watchdog fires
        xfer(32'h2000_0000, 1'b0, 32'h0, 4'hF, -1, 0, -1, 32'h0);
        check("to_stb", r_stb_or, 6'b000100);
        check("to_stb_cnt", r_stb_cnt, 4);
        check("to_resp_cyc", r_resp, 6);
        check("to_ack_err", {r_ack, r_err, r_both, r_post}, 4'b0100);
        check("to_pulse", r_to_cnt, 1);
        check("to_err_adr", err_adr_o, 32'h2000_0000);

        // UART, ack on the expiry cycle wins
        xfer(32'h2000_0000, 1'b0, 32'h0, 4'hF, 2, 3, -1, 32'h1234_5678);
        check("late_stb_cnt", r_stb_cnt, 4);
        check("late_ack_err", {r_ack, r_err, r_both, r_post}, 4'b1000);
        check("late_to", r_to_cnt, 0);
        check("late_dat", wbm_dat_o, 32'h1234_5678);

        // Slave1 acks spuriously while slave0 is selected
        xfer(32'h0000_0020, 1'b0, 32'h0, 4'hF, 0, 2, 1, 32'hCAFE_F00D);
        check("spur_stb", r_stb_or, 6'b000001);
        check("spur_stb_cnt", r_stb_cnt, 3);
        check("spur_resp_cyc", r_resp, 5);
        check("spur_dat", wbm_dat_o, 32'hCAFE_F00D);

        // Abort by dropping cyc mid-ACCESS
        wbm_adr_i = 32'h2000_0000; wbm_we_i = 0; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick();
        check("abort_stb_up", wbs_stb_o, 6'b000100);
        tick();
        wbm_cyc_i = 0; wbm_stb_i = 0;
        tick();
        check("abort_clear", {wbs_cyc_o, wbs_stb_o}, 0);
        r_post = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            r_post |= wbm_ack_o | wbm_err_o | timeout_o;
        end
        check("abort_no_resp", r_post, 0);

        // Async reset mid-ACCESS
        wbm_adr_i = 32'h1000_0000; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick();
        check("rst2_stb_up", wbs_stb_o, 6'b000010);
        #2 rst = 1'b1;
        #1;
        check("rst2_cyc_stb", {wbs_cyc_o, wbs_stb_o}, 0);
        check("rst2_bus", {wbs_adr_o, err_adr_o, wbm_dat_o}, 0);
        check("rst2_resp", {wbm_ack_o, wbm_err_o, timeout_o}, 0);
        wbm_cyc_i = 0; wbm_stb_i = 0;
        @(negedge clk);
        rst = 1'b0;

        xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, 1, 0, -1, 32'h0055_AA00);
        check("post_rst_stb", r_stb_or, 6'b000010);
        check("post_rst_resp_cyc", r_resp, 3);
        check("post_rst_ack_err", {r_ack, r_err, r_both, r_post}, 4'b1000);
        check("post_rst_dat", wbm_dat_o, 32'h0055_AA00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
